cassette_writer: RTL
====================

CASSETTE_WRITER -- requirements
Module: cassette_writer

Interface
REQ-001 SHALL have parameter THRESH, default 13333, short/long period boundary in ce ticks (625 us at 21.333 MHz).
REQ-002 SHALL have parameter MIN_PER, default 4000, minimum valid period in ce ticks; shorter edges are glitches.
REQ-003 SHALL have parameter MAX_PER, default 40000, maximum valid period in ce ticks; longer is a timeout.
REQ-004 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset; synchronous, active-low.
REQ-006 SHALL have port ce  in  1  tick enable (21.333 MHz); period counters advance only when high.
REQ-007 SHALL have port record  in  1  recording armed (motor on); low aborts any byte in progress.
REQ-008 SHALL have port rewind  in  1  level; clears the write pointer and sticky flags.
REQ-009 SHALL have port tape_in  in  1  asynchronous SVI cassette-out FSK bit.
REQ-010 SHALL have port sdram_addr  out  18  byte address of the current or last write.
REQ-011 SHALL have port sdram_data  out  8  byte to write.
REQ-012 SHALL have port sdram_req  out  1  toggle request.
REQ-013 SHALL have port sdram_ack  in  1  toggle acknowledge.
REQ-014 SHALL have port end_addr  out  18  number of bytes committed (next free address).
REQ-015 SHALL have port status  out  3  {overrun, full, busy}.

Function
REQ-016 tape_in SHALL pass through a 2-flop synchronizer; a rising edge is detected on the synchronized signal.
REQ-017 The period counter SHALL count ce ticks since the last accepted rising edge, saturate at MAX_PER+1, and clear on each accepted edge.
REQ-018 Edges with period < MIN_PER SHALL be ignored; the counter continues.
REQ-019 Periods MIN_PER..THRESH-1 are short: with half=0, set half; with half=1, clear half and emit bit 1.
REQ-020 Periods THRESH..MAX_PER are long: with half=0, emit bit 0; with half=1, framing error (clear half, go to HUNT, no bit).
REQ-021 When the counter exceeds MAX_PER (timeout), the block SHALL go to HUNT, clear half, and mark the period invalid; the next edge only restarts measurement.
REQ-022 The first edge after reset, rewind or record rising SHALL only start measurement.
REQ-023 The FSM SHALL have states HUNT, DATA and STOP.
  - HUNT: bit 1 stays in HUNT (leader); bit 0 goes to DATA with bitcnt=0.
  - DATA: shift right, LSB first (sr <= {bit, sr[7:1]}); after the 8th bit, go to STOP.
  - STOP: bit 1 commits the byte and goes to HUNT; bit 0 discards it and goes to HUNT.
REQ-024 A commit SHALL take effect the cycle after the stop bit is classified.
  - Sets sdram_data=sr and sdram_addr=wr_addr.
  - Increments wr_addr.
  - Toggles sdram_req and sets pending.
REQ-025 pending SHALL clear on the first cycle where sdram_ack == sdram_req; sdram_req never toggles while pending.
REQ-026 A commit while pending SHALL drop the byte, set overrun (sticky), and leave wr_addr unchanged.
REQ-027 With wr_addr == 18'h3FFFF, commits SHALL be dropped and full set; wrap-around is never permitted.
REQ-028 end_addr SHALL equal wr_addr.
REQ-029 busy SHALL equal (state != HUNT) | pending.
REQ-030 record low SHALL force HUNT, clear half and discard the byte in progress; an outstanding handshake still completes.
REQ-031 rewind SHALL clear wr_addr, overrun, full, half and FSM state.
  - sdram_req is not altered; pending still resolves via ack.
  - A commit in the same cycle as rewind is discarded (rewind wins).

Reset
REQ-032 With reset_n low at a clk edge, the block SHALL load the reset state.
  - Outputs: sdram_req=0, sdram_addr=0, sdram_data=0, end_addr=0, status=3'b000.
  - Internal: state=HUNT, half=0, pending=0, counter=0, synchronizer=0.
REQ-033 Reset mid-handshake SHALL abandon the request; the controller ack must also reset.

Verification (bench: ce every 2nd clk, THRESH=100, MIN_PER=30, MAX_PER=300, ack echoed 4 clks after req)
REQ-034 Leader of 16 short periods (50), then byte 0xA5 framed 0 / A5 LSB-first / 1, with bit0 = one 150 period and bit1 = two 50 periods -> one sdram_req toggle, sdram_data=0xA5, sdram_addr=0, end_addr=1.
REQ-035 Ack withheld and two bytes 0x12, 0x34 sent -> only 0x12 written, status[2]=1, end_addr=1.
REQ-036 10-tick glitch pulses inserted mid-byte 0x5A -> 0x5A written correctly.
REQ-037 Stop bit sent as long period -> no req toggle, end_addr unchanged, FSM back in HUNT (busy=0).
REQ-038 Three bytes written, then rewind 1 clk, then byte 0x77 -> end_addr 3 -> 0 -> 1, sdram_addr=0, status[2]=0.
REQ-039 reset_n low during DATA after 4 bits -> all outputs at reset values next cycle; a subsequent full byte 0xC3 is written at address 0.

Source files
------------

// File: rtl/cassette_writer_if.sv
// SDRAM write-port bundle between the cassette writer and the memory controller.
// Requests use toggle signalling: the writer flips sdram_req and the controller echoes it on sdram_ack.
interface cassette_writer_if;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 8;

  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_data;
  logic          sdram_req;
  logic          sdram_ack;

  modport master (output sdram_addr, sdram_data, sdram_req, input sdram_ack);
  modport slave  (input sdram_addr, sdram_data, sdram_req, output sdram_ack);
endinterface

// File: rtl/cassette_writer.sv
// SVI cassette recorder: decodes the FSK tape bit stream into framed bytes and
// streams each good byte to SDRAM over a toggle request/acknowledge handshake.
module cassette_writer #(
  parameter int unsigned THRESH  = 13333,
  parameter int unsigned MIN_PER = 4000,
  parameter int unsigned MAX_PER = 40000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic               record,
  input  logic               rewind,
  input  logic               tape_in,
  cassette_writer_if.master  mem,
  output logic [17:0]        end_addr,
  output logic [2:0]         status
);

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = $clog2(MAX_PER + 2);
  localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_PER + 1);
  localparam logic [CW-1:0] CNT_MIN  = CW'(MIN_PER);
  localparam logic [CW-1:0] CNT_THR  = CW'(THRESH);
  localparam logic [AW-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {HUNT, DATA, STOP} state_e;

  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          half_q, half_d;
  state_e        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [DW-1:0] sr_q, sr_d;
  logic          commit_q, commit_d;
  logic          pending_q, pending_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          overrun_q, overrun_d;
  logic          full_q, full_d;
  logic          busy_q, busy_d;

  logic rise, timeout, accept, measured, have_bit, bit_val;

  always_comb begin
    sync1_d   = tape_in;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    half_d    = half_q;
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    sr_d      = sr_q;
    commit_d  = 1'b0;
    pending_d = pending_q;
    req_d     = req_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_addr_d = wr_addr_q;
    overrun_d = overrun_q;
    full_d    = full_q;
    have_bit  = 1'b0;
    bit_val   = 1'b0;

    // A valid period ends at an edge that is neither a glitch nor past the timeout.
    rise     = sync2_q & ~prev_q;
    timeout  = (cnt_q == CNT_SAT);
    measured = rise & valid_q & ~timeout & (cnt_q >= CNT_MIN);
    accept   = rise & (~valid_q | timeout | (cnt_q >= CNT_MIN));

    if (ce && !timeout) cnt_d = cnt_q + CW'(1);
    if (timeout) begin
      state_d = HUNT;
      half_d  = 1'b0;
      valid_d = 1'b0;
    end
    if (accept) begin
      cnt_d   = '0;
      valid_d = 1'b1;
    end

    // One long period is a 0; two short periods are a 1; long after a lone short is a framing error.
    if (measured) begin
      if (cnt_q < CNT_THR) begin
        if (half_q) begin
          half_d   = 1'b0;
          have_bit = 1'b1;
          bit_val  = 1'b1;
        end else begin
          half_d = 1'b1;
        end
      end else if (half_q) begin
        half_d  = 1'b0;
        state_d = HUNT;
      end else begin
        have_bit = 1'b1;
      end
    end

    if (have_bit) begin
      unique case (state_q)
        HUNT: begin
          if (!bit_val) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end
        end
        DATA: begin
          sr_d     = {bit_val, sr_q[DW-1:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = STOP;
        end
        STOP: begin
          state_d  = HUNT;
          commit_d = bit_val;
        end
        default: state_d = HUNT;
      endcase
    end

    if (!record) begin
      state_d  = HUNT;
      half_d   = 1'b0;
      valid_d  = 1'b0;
      commit_d = 1'b0;
    end

    if (pending_q && (mem.sdram_ack == req_q)) pending_d = 1'b0;

    // Only one request may be outstanding; the address never wraps.
    if (commit_q && !rewind) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else if (wr_addr_q == ADDR_MAX) begin
        full_d = 1'b1;
      end else begin
        data_d    = sr_q;
        addr_d    = wr_addr_q;
        wr_addr_d = wr_addr_q + AW'(1);
        req_d     = ~req_q;
        pending_d = 1'b1;
      end
    end

    if (rewind) begin
      wr_addr_d = '0;
      overrun_d = 1'b0;
      full_d    = 1'b0;
      half_d    = 1'b0;
      state_d   = HUNT;
      valid_d   = 1'b0;
      commit_d  = 1'b0;
    end

    busy_d = (state_d != HUNT) | pending_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      half_q    <= 1'b0;
      state_q   <= HUNT;
      bitcnt_q  <= 3'd0;
      sr_q      <= '0;
      commit_q  <= 1'b0;
      pending_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_addr_q <= '0;
      overrun_q <= 1'b0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      half_q    <= half_d;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      sr_q      <= sr_d;
      commit_q  <= commit_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_addr_q <= wr_addr_d;
      overrun_q <= overrun_d;
      full_q    <= full_d;
      busy_q    <= busy_d;
    end
  end

  assign mem.sdram_addr = addr_q;
  assign mem.sdram_data = data_q;
  assign mem.sdram_req  = req_q;
  assign end_addr       = wr_addr_q;
  assign status         = {overrun_q, full_q, busy_q};

endmodule
